usb_tx_reader: RTL

//  Drains response/ADC frames that the command engine writes into the TX page buffer.

---
 rtl/usb_tx_reader.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/usb_tx_reader.sv
// Streams completed TX buffer pages into the USB slave FIFO with full-flag flow control.
// Optional feature macro: USB_TX_ZERO_TRIM_EN (suppress the trailing all-zero words of a page).
module usb_tx_reader #(
  parameter int BADDR_NBIT = 2,
  parameter int ADDR_NBIT  = 8,
  parameter int DATA_NBIT  = 16
) (
  input  logic                            mclk,
  input  logic                            rst,
  input  logic                            tx_eop,
  input  logic [BADDR_NBIT-1:0]           tx_baddr,
  output logic                            buf_rd_en,
  output logic [BADDR_NBIT+ADDR_NBIT-1:0] buf_rd_addr,
  input  logic [DATA_NBIT-1:0]            buf_rd_data,
  input  logic                            usb_full,
  output logic                            usb_wr,
  output logic [DATA_NBIT-1:0]            usb_data,
  output logic                            usb_pktend,
  output logic                            busy,
  output logic                            ovf
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, PKTEND} state_t;

  state_t                  state_reg, state_next;
  logic [BADDR_NBIT-1:0]   page_reg, page_next;
  logic                    pend_valid_reg, pend_valid_next;
  logic [BADDR_NBIT-1:0]   pend_page_reg, pend_page_next;
  logic                    ovf_reg, ovf_next;
  logic [ADDR_NBIT-1:0]    word_addr_reg;
  logic                    inflight_reg;
  logic [DATA_NBIT-1:0]    skid_mem [2];
  logic                    skid_wr_ptr_reg, skid_rd_ptr_reg;
  logic [1:0]              skid_count_reg, skid_count_next;
  logic                    skid_push, skid_pop;
  logic [DATA_NBIT-1:0]    skid_head;
  logic [2:0]              occ;
  logic                    rd_en;
  logic                    wr_c;
  logic [DATA_NBIT-1:0]    data_c;

`ifdef USB_TX_ZERO_TRIM_EN
  logic [ADDR_NBIT:0]      zero_run_reg;
  logic                    zero_inc, zero_dec;
`endif

  assign skid_head       = skid_mem[skid_rd_ptr_reg];
  assign skid_push       = inflight_reg;
  assign skid_count_next = skid_count_reg + {1'b0, skid_push} - {1'b0, skid_pop};
  // Occupancy after this cycle's pop keeps one read per cycle flowing through a 2-entry skid.
  assign occ             = 3'(skid_count_reg) + 3'(inflight_reg) - 3'(skid_pop);

  // Write side: head of the skid goes out whenever the FIFO can take it.
  always_comb begin
    wr_c     = 1'b0;
    data_c   = skid_head;
    skid_pop = 1'b0;
`ifdef USB_TX_ZERO_TRIM_EN
    zero_inc = 1'b0;
    zero_dec = 1'b0;
    if (skid_count_reg != 2'd0) begin
      if (skid_head == '0) begin
        // Zero words are only counted; they are replayed if a non-zero word follows.
        skid_pop = 1'b1;
        zero_inc = 1'b1;
      end else if (zero_run_reg != '0) begin
        wr_c     = !usb_full;
        data_c   = '0;
        zero_dec = !usb_full;
      end else begin
        wr_c     = !usb_full;
        skid_pop = !usb_full;
      end
    end
`else
    if (skid_count_reg != 2'd0) begin
      wr_c     = !usb_full;
      skid_pop = !usb_full;
    end
`endif
  end

  always_comb begin
    state_next      = state_reg;
    page_next       = page_reg;
    pend_valid_next = pend_valid_reg;
    pend_page_next  = pend_page_reg;
    ovf_next        = ovf_reg;
    rd_en           = 1'b0;
    usb_pktend      = 1'b0;
    if (tx_eop && (state_reg == FETCH || state_reg == DRAIN)) begin
      if (pend_valid_reg) begin
        ovf_next = 1'b1;
      end else begin
        pend_valid_next = 1'b1;
        pend_page_next  = tx_baddr;
      end
    end
    case (state_reg)
      IDLE: begin
        if (tx_eop) begin
          page_next  = tx_baddr;
          state_next = FETCH;
        end
      end
      FETCH: begin
        rd_en = (occ < 3'd2);
        if (rd_en && word_addr_reg == '1) state_next = DRAIN;
      end
      DRAIN: begin
        if (!inflight_reg && skid_count_next == 2'd0) state_next = PKTEND;
      end
      PKTEND: begin
        usb_pktend = 1'b1;
        // A frame announced during pktend frees or reuses the pending slot, so none is lost.
        if (pend_valid_reg) begin
          page_next       = pend_page_reg;
          state_next      = FETCH;
          pend_valid_next = tx_eop;
          pend_page_next  = tx_baddr;
        end else if (tx_eop) begin
          page_next  = tx_baddr;
          state_next = FETCH;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      state_reg      <= IDLE;
      page_reg       <= '0;
      pend_valid_reg <= 1'b0;
      pend_page_reg  <= '0;
      ovf_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      page_reg       <= page_next;
      pend_valid_reg <= pend_valid_next;
      pend_page_reg  <= pend_page_next;
      ovf_reg        <= ovf_next;
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      word_addr_reg   <= '0;
      inflight_reg    <= 1'b0;
      skid_wr_ptr_reg <= 1'b0;
      skid_rd_ptr_reg <= 1'b0;
      skid_count_reg  <= 2'd0;
    end else begin
      inflight_reg   <= rd_en;
      skid_count_reg <= skid_count_next;
      if (rd_en)     word_addr_reg   <= word_addr_reg + 1'b1;
      if (skid_push) skid_wr_ptr_reg <= ~skid_wr_ptr_reg;
      if (skid_pop)  skid_rd_ptr_reg <= ~skid_rd_ptr_reg;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_skid
    always_ff @(posedge mclk) begin
      if (rst) begin
        skid_mem[gi] <= '0;
      end else if (skid_push && int'(skid_wr_ptr_reg) == gi) begin
        skid_mem[gi] <= buf_rd_data;
      end
    end
  end

`ifdef USB_TX_ZERO_TRIM_EN
  // A zero run still pending at page end is the trimmed tail and is simply dropped.
  always_ff @(posedge mclk) begin
    if (rst || state_reg == PKTEND) begin
      zero_run_reg <= '0;
    end else if (zero_inc) begin
      zero_run_reg <= zero_run_reg + 1'b1;
    end else if (zero_dec) begin
      zero_run_reg <= zero_run_reg - 1'b1;
    end
  end
`endif

  assign buf_rd_en   = rd_en;
  assign buf_rd_addr = {page_reg, word_addr_reg};
  assign usb_wr      = wr_c;
  assign usb_data    = data_c;
  assign busy        = (state_reg != IDLE);
  assign ovf         = ovf_reg;

endmodule
